pipe_adder: RTL and testbench

Parametrised, pipelined successor to the team's 8-bit adder. It adds two WIDTH-bit operands plus carry-in, or optionally subtracts them, through a configurable number of register stages. Operand and result ports use valid/ready handshakes. A wrapping transaction counter is included for scoreboard cross-checks. It sits between a stimulus/driver-side producer and a result consumer, replacing the fixed-width combinational adder in the adder testbench environment.

---
 rtl/pipe_adder.sv | 119 +++++++++++
 tb/tb_pipe_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder (optional subtract via ADDER_SUB_EN) with valid/ready
// handshakes, a global-stall pipeline of STAGES registers and a wrapping output counter.

// One pipeline register: valid bit plus result word; data only reloads under a valid beat.
module pipe_adder_stage #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);
    logic          vld_q, vld_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (adv) begin
            vld_d = vld_i;
            if (vld_i) data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic [CNT_W-1:0] txn_count
);
    // Index 0 is the incoming beat; index k+1 is the output of register stage k.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH:0]   data_pipe;
    logic                       stall;
    logic                       adv;
    logic [WIDTH:0]             sum_add;
    logic [WIDTH:0]             result;
    logic [CNT_W-1:0]           txn_count_q, txn_count_d;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;

    assign sum_add = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};

`ifdef ADDER_SUB_EN
    // Two's complement difference in WIDTH+1 bits: MSB is the borrow.
    logic [WIDTH:0] diff;
    assign diff   = {1'b0, in1} - {1'b0, in2};
    assign result = op_sub ? diff : sum_add;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign result        = sum_add;
`endif

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = result;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        pipe_adder_stage #(.DW(WIDTH + 1)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .adv    (adv),
            .vld_i  (vld_pipe[s]),
            .data_i (data_pipe[s]),
            .vld_o  (vld_pipe[s+1]),
            .data_o (data_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign out       = data_pipe[STAGES];

    always_comb begin
        txn_count_d = txn_count_q;
        if (out_valid && out_ready) txn_count_d = txn_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) txn_count_q <= '0;
        else        txn_count_q <= txn_count_d;
    end

    assign txn_count = txn_count_q;

    // A presented result must not change or vanish until the consumer takes it.
    a_out_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out)));
endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=8, STAGES=2, CNT_W=4) with a result scoreboard queue.
module tb_pipe_adder;
    localparam int W = 8;
    localparam int S = 2;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] in1, in2;
    logic         cin, op_sub;
    logic         out_valid, out_ready;
    logic [W:0]   out;
    logic [C-1:0] txn_count;

    int           errors = 0;
    int           checks = 0;
    logic [W:0]   exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W:0]   prev_out = '0;

    pipe_adder #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard and hold-while-stalled monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_out", 32'(out), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_out: observed %0h expected none", out);
                end
                if (exp_q.size() != 0) chk("sb_out", 32'(out), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W:0] expv);
        int bound = 0;
        in_valid = 1'b1; in1 = a; in2 = b; cin = c; op_sub = s;
        @(negedge clk);
        while (!in_ready && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int bound = 0;
        while (exp_q.size() != 0 && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int cyc;
        reset = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #5 reset = 1'b1;
        @(posedge clk); #1;

        // Basic add with latency check
        send(8'd200, 8'd100, 1'b1, 1'b0, 9'h12D);
        @(negedge clk);
        chk("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_out", 32'(out), 32'h12D);
        @(negedge clk);
        chk("txn_one", 32'(txn_count), 32'd1);
        @(posedge clk); #1;

        // Overflow boundary, zero, subtract
        send(8'd255, 8'd255, 1'b1, 1'b0, 9'd511);
        send(8'd0, 8'd0, 1'b0, 1'b0, 9'd0);
`ifdef ADDER_SUB_EN
        send(8'd5, 8'd7, 1'b1, 1'b1, 9'h1FE);
`else
        send(8'd5, 8'd7, 1'b1, 1'b1, 9'd13);
`endif
        drain();
        chk("txn_four", 32'(txn_count), 32'd4);

        // Backpressure: out_ready low in cycles 3..5 of the stream
        reset_pulse();
        idx = 1;
        cyc = 0;
        while ((idx <= 6 || exp_q.size() != 0) && cyc < 80) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (idx <= 6);
            in1 = 8'(idx); in2 = '0; cin = 1'b0; op_sub = 1'b0;
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5) chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back(9'(idx));
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_sent", 32'(idx), 32'd7);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_txn", 32'(txn_count), 32'd6);

        // Reset with two results in flight
        send(8'd1, 8'd2, 1'b0, 1'b0, 9'd3);
        send(8'd3, 8'd4, 1'b0, 1'b0, 9'd7);
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_txn", 32'(txn_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'd10, 8'd20, 1'b0, 1'b0, 9'd30);
        drain();
        chk("post_rst_txn", 32'(txn_count), 32'd1);

        // Counter wrap at CNT_W=4: 17 transfers
        reset_pulse();
        for (int i = 0; i < 17; i++) send(8'(i), 8'd1, 1'b0, 1'b0, 9'(i + 1));
        drain();
        chk("wrap_txn", 32'(txn_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
